// File: rtl/udma_hyper_cfg_master.sv
// Command-queue master for the HyperBus config register bus: queued read/write commands are
// issued one at a time, read data comes back on a valid/ready response port, stalls time out.
module udma_hyper_cfg_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_rwn_i,
    input  logic [4:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [4:0]  rsp_addr_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic [31:0] cfg_data_o,
    output logic [4:0]  cfg_addr_o,
    output logic        cfg_valid_o,
    output logic        cfg_reg_rwn_o,
    input  logic [31:0] cfg_data_i,
    input  logic        cfg_ready_i,
    output logic        busy_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WAIT_LIMIT = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RSP} state_t;

    state_t state, state_next;

    logic        fifo_rwn  [FIFO_DEPTH];
    logic [4:0]  fifo_addr [FIFO_DEPTH];
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [TW-1:0] wait_cnt;

    logic        head_rwn;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic        in_issue, push, pop, done, timeout;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        err;

    assign head_rwn  = fifo_rwn[rd_ptr];
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    assign in_issue    = (state == ISSUE);
    assign cmd_ready_o = (count != CW'(FIFO_DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    assign done        = in_issue && cfg_ready_i;
    // A ready arriving in the limit cycle wins over the timeout.
    assign timeout     = in_issue && !cfg_ready_i && (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LIMIT);
    assign pop         = done || timeout;

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rwn[wr_ptr]  <= cmd_rwn_i;
            fifo_addr[wr_ptr] <= cmd_addr_i;
            fifo_data[wr_ptr] <= cmd_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
            rsp_addr <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (in_issue && !pop && (TIMEOUT_CYCLES != 0)) wait_cnt <= wait_cnt + 1'b1;
            else                                           wait_cnt <= '0;
            if (pop && head_rwn) begin
                rsp_addr <= head_addr;
                rsp_data <= timeout ? 32'd0 : cfg_data_i;
                rsp_err  <= timeout;
            end
            if (timeout)        err <= 1'b1;
            else if (err_clr_i) err <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (count != '0 || push) state_next = ISSUE;
            ISSUE: begin
                if (pop) begin
                    if (head_rwn)               state_next = RSP;
                    else if (count_next != '0) state_next = ISSUE;
                    else                        state_next = IDLE;
                end
            end
            RSP:   if (rsp_ready_i) state_next = (count_next != '0) ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cfg_valid_o   = in_issue;
        cfg_addr_o    = in_issue ? head_addr : 5'd0;
        cfg_reg_rwn_o = in_issue && head_rwn;
        cfg_data_o    = (in_issue && !head_rwn) ? head_data : 32'd0;
        rsp_valid_o   = (state == RSP);
        rsp_addr_o    = rsp_addr;
        rsp_data_o    = rsp_data;
        rsp_err_o     = rsp_err;
        busy_o        = (count != '0) || (state != IDLE);
        err_o         = err;
    end

endmodule

// File: tb/tb_udma_hyper_cfg_master.sv
// Directed bench for udma_hyper_cfg_master: back-to-back writes, reads, FIFO full,
// timeout and its boundary, and reset while busy.
module tb_udma_hyper_cfg_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_rwn;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic [4:0]  cfg_addr;
    logic        cfg_valid, cfg_rwn, cfg_ready;
    logic        busy, err, err_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    udma_hyper_cfg_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rwn_i(cmd_rwn),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_addr_o(rsp_addr),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .cfg_data_o(cfg_wdata), .cfg_addr_o(cfg_addr), .cfg_valid_o(cfg_valid),
        .cfg_reg_rwn_o(cfg_rwn), .cfg_data_i(cfg_rdata), .cfg_ready_i(cfg_ready),
        .busy_o(busy), .err_o(err), .err_clr_i(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic rwn, input logic [4:0] addr,
                                  input logic [31:0] data);
        cmd_valid = valid;
        cmd_rwn   = rwn;
        cmd_addr  = addr;
        cmd_data  = data;
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0);
        rsp_ready = 1'b0; cfg_rdata = 32'd0; cfg_ready = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        check_output("rst_cmd_ready", cmd_ready, 1);
        check_output("rst_cfg_valid", cfg_valid, 0);
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_err", err, 0);
        check_output("rst_cfg_addr", cfg_addr, 0);
        rst = 1'b0;
        tick();

        // Two back-to-back writes with ready tied high
        cfg_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 5'd3, 32'd665);
        tick();
        check_output("t1_valid0", cfg_valid, 1);
        check_output("t1_addr0", cfg_addr, 3);
        check_output("t1_data0", cfg_wdata, 665);
        check_output("t1_rwn0", cfg_rwn, 0);
        apply_stimulus(1'b1, 1'b0, 5'd8, 32'd2);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0);
        check_output("t1_valid1", cfg_valid, 1);
        check_output("t1_addr1", cfg_addr, 8);
        check_output("t1_data1", cfg_wdata, 2);
        tick();
        check_output("t1_valid_end", cfg_valid, 0);
        check_output("t1_busy_end", busy, 0);

        // Read returning 6, response held while a write waits behind it
        cfg_rdata = 32'h6;
        apply_stimulus(1'b1, 1'b1, 5'd1, 32'hFFFF_FFFF);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0);
        check_output("t2_valid", cfg_valid, 1);
        check_output("t2_rwn", cfg_rwn, 1);
        check_output("t2_addr", cfg_addr, 1);
        check_output("t2_rdata_zero", cfg_wdata, 0);
        tick();
        check_output("t2_rsp_valid", rsp_valid, 1);
        check_output("t2_rsp_addr", rsp_addr, 1);
        check_output("t2_rsp_data", rsp_data, 6);
        check_output("t2_rsp_err", rsp_err, 0);
        check_output("t2_cfg_idle", cfg_valid, 0);
        apply_stimulus(1'b1, 1'b0, 5'd4, 32'h44);
        for (int i = 0; i < 5; i++) begin
            tick();
            apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0);
            check_output("t2_hold_valid", rsp_valid, 1);
            check_output("t2_hold_data", rsp_data, 6);
            check_output("t2_no_issue", cfg_valid, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("t2_rsp_done", rsp_valid, 0);
        check_output("t2_next_valid", cfg_valid, 1);
        check_output("t2_next_addr", cfg_addr, 4);
        check_output("t2_next_data", cfg_wdata, 32'h44);
        tick();
        check_output("t2_busy_end", busy, 0);

        // Fill the FIFO while the responder stalls, then drain in order
        cfg_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 5'd10, 32'h100);
        tick();
        check_output("t3_valid", cfg_valid, 1);
        for (int i = 1; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 5'(10 + i), 32'h100 + i);
            tick();
            check_output("t3_fill_ready", cmd_ready, (i < 3) ? 1 : 0);
        end
        apply_stimulus(1'b1, 1'b0, 5'd14, 32'h104);
        tick();
        check_output("t3_full", cmd_ready, 0);
        check_output("t3_head_stable", cfg_addr, 10);
        cfg_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0);
            check_output("t3_drain_valid", cfg_valid, 1);
            check_output("t3_drain_addr", cfg_addr, 10 + k);
            check_output("t3_drain_data", cfg_wdata, 32'h100 + k);
            if (k == 1) check_output("t3_space", cmd_ready, 1);
        end
        tick();
        check_output("t3_valid_end", cfg_valid, 0);
        check_output("t3_busy_end", busy, 0);
        check_output("t3_no_err", err, 0);

        // Read that times out after 8 wait cycles
        cfg_ready = 1'b0;
        cfg_rdata = 32'hDEAD;
        apply_stimulus(1'b1, 1'b1, 5'd2, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0);
        for (int c = 1; c < 8; c++) begin
            tick();
            check_output("t4_waiting", cfg_valid, 1);
        end
        tick();
        check_output("t4_valid_drop", cfg_valid, 0);
        check_output("t4_rsp_valid", rsp_valid, 1);
        check_output("t4_rsp_err", rsp_err, 1);
        check_output("t4_rsp_data", rsp_data, 0);
        check_output("t4_rsp_addr", rsp_addr, 2);
        check_output("t4_err", err, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("t4_rsp_done", rsp_valid, 0);
        check_output("t4_err_sticky", err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_output("t4_err_clr", err, 0);

        // Ready on the 8th wait cycle is a normal completion
        cfg_rdata = 32'h1234;
        apply_stimulus(1'b1, 1'b1, 5'd5, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0);
        for (int c = 1; c < 8; c++) tick();
        check_output("t5_still_valid", cfg_valid, 1);
        cfg_ready = 1'b1;
        tick();
        cfg_ready = 1'b0;
        check_output("t5_rsp_valid", rsp_valid, 1);
        check_output("t5_rsp_data", rsp_data, 32'h1234);
        check_output("t5_rsp_err", rsp_err, 0);
        check_output("t5_err", err, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("t5_busy_end", busy, 0);

        // Reset while issuing with three commands queued
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, 5'(20 + i), 32'h200 + i);
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0);
        check_output("t6_pre_valid", cfg_valid, 1);
        check_output("t6_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_output("t6_async_valid", cfg_valid, 0);
        check_output("t6_async_busy", busy, 0);
        check_output("t6_async_ready", cmd_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        check_output("t6_no_issue", cfg_valid, 0);
        check_output("t6_no_rsp", rsp_valid, 0);
        check_output("t6_idle", busy, 0);
        cfg_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 5'd7, 32'h77);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0);
        check_output("t6_new_valid", cfg_valid, 1);
        check_output("t6_new_addr", cfg_addr, 7);
        check_output("t6_new_data", cfg_wdata, 32'h77);
        tick();
        check_output("t6_new_done", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
